// File: rtl/svreal_mul_sched.sv
// Round-robin scheduler feeding one shared pipelined fixed-point multiplier.
// Products are aligned from exponent a_exponent+b_exponent to c_exponent on the way out.

module svreal_mul_sched_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cke,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (cke) begin
      out_vld <= in_vld;
      if (in_vld) out_data <= in_data;
    end
  end
endmodule

module svreal_mul_sched #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 18,
  parameter int OUT_WIDTH = 18,
  parameter int MUL_LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   a_significand,
  input  logic [N_REQ*WIDTH-1:0]   b_significand,
  input  logic [15:0]              a_exponent,
  input  logic [15:0]              b_exponent,
  input  logic [15:0]              c_exponent,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [OUT_WIDTH-1:0]     c_significand,
  output logic                     busy
);
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = 2 * WIDTH;
  localparam int EW  = PW + OUT_WIDTH;

  typedef struct packed {
    logic [IDW-1:0]       id;
    logic signed [PW-1:0] prod;
  } ent_t;

  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          grant;
  logic [IDW-1:0]          cand;
  logic                    any;
  logic                    hs;
  logic signed [WIDTH-1:0] a_sel;
  logic signed [WIDTH-1:0] b_sel;
  ent_t                    ent_in;
  logic [MUL_LAT:0]        vld_pipe;
  ent_t [MUL_LAT:0]        ent_pipe;

  // first valid requester scanning upward from ptr, wrapping at N_REQ
  always_comb begin
    grant = '0;
    cand  = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!any && req_valid[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

  assign hs = any && cke && !rst;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDW'(i)) begin
        req_ready[i] = hs;
        a_sel        = a_significand[i*WIDTH +: WIDTH];
        b_sel        = b_significand[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (hs) ptr <= (grant == IDW'(N_REQ-1)) ? '0 : grant + IDW'(1);
  end

  always_comb begin
    ent_in.id   = grant;
    ent_in.prod = a_sel * b_sel;
  end

  assign vld_pipe[0] = hs;
  assign ent_pipe[0] = ent_in;

  for (genvar s = 1; s <= MUL_LAT; s++) begin : g_stg
    svreal_mul_sched_stage #(.DW($bits(ent_t))) u_stg (
      .clk      (clk),
      .rst      (rst),
      .cke      (cke),
      .in_vld   (vld_pipe[s-1]),
      .in_data  (ent_pipe[s-1]),
      .out_vld  (vld_pipe[s]),
      .out_data (ent_pipe[s])
    );
  end

  assign busy = |vld_pipe[MUL_LAT:1];

  // alignment shift; 18 bits hold any sum/difference of three 16-bit exponents
  logic signed [17:0]    sh;
  logic [17:0]           shamt;
  logic signed [EW-1:0]  ext;
  logic [OUT_WIDTH-1:0]  c_nxt;

  always_comb begin
    sh    = {{2{a_exponent[15]}}, a_exponent} + {{2{b_exponent[15]}}, b_exponent}
          - {{2{c_exponent[15]}}, c_exponent};
    shamt = sh[17] ? 18'(-sh) : 18'(sh);
    ext   = {{OUT_WIDTH{ent_pipe[MUL_LAT].prod[PW-1]}}, ent_pipe[MUL_LAT].prod};
    c_nxt = sh[17] ? OUT_WIDTH'(ext >>> shamt) : OUT_WIDTH'(ext <<< shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      c_significand <= '0;
    end else if (cke) begin
      resp_valid <= vld_pipe[MUL_LAT];
      if (vld_pipe[MUL_LAT]) begin
        resp_id       <= ent_pipe[MUL_LAT].id;
        c_significand <= c_nxt;
      end
    end
  end
endmodule

// File: tb/tb_svreal_mul_sched.sv
// Bench for svreal_mul_sched: queue-based reference model plus directed grant/latency checks.

module tb_svreal_mul_sched;
  localparam int N  = 4;
  localparam int W  = 18;
  localparam int OW = 18;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cke = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  a_sig = '0;
  logic [N*W-1:0]  b_sig = '0;
  logic [15:0]     ae = 16'hfff6, be = 16'hfff6, ce = 16'hfff6;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [OW-1:0]   c_sig;
  logic            busy;

  svreal_mul_sched #(.N_REQ(N), .WIDTH(W), .OUT_WIDTH(OW), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .cke(cke), .req_valid(req_valid), .req_ready(req_ready),
    .a_significand(a_sig), .b_significand(b_sig),
    .a_exponent(ae), .b_exponent(be), .c_exponent(ce),
    .resp_valid(resp_valid), .resp_id(resp_id), .c_significand(c_sig), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [OW-1:0] c;
  } exp_t;

  exp_t          q[$];
  int            mptr = 0;
  int            ncnt = 0;
  logic          exp_rv = 1'b0;
  int            exp_id = 0;
  logic [OW-1:0] exp_c = '0;

  function automatic logic [OW-1:0] mdl(int a, int b, int e1, int e2, int e3);
    longint p = longint'(a) * longint'(b);
    int sh = e1 + e2 - e3;
    longint v;
    if (sh >= 0) v = (sh >= 64) ? 64'sd0 : (p <<< sh);
    else         v = (-sh >= 64) ? ((p < 0) ? -64'sd1 : 64'sd0) : (p >>> (-sh));
    return v[OW-1:0];
  endfunction

  function automatic int mgrant(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int opnd(logic [N*W-1:0] s, int i);
    logic [W-1:0] x = s[i*W +: W];
    return int'($signed(x));
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        mptr = 0; exp_rv = 1'b0; exp_id = 0; exp_c = '0;
      end else if (cke) begin
        int g;
        exp_t e;
        ncnt++;
        g = mgrant(req_valid, mptr);
        if (g >= 0) begin
          e.due = ncnt + L;
          e.id  = g;
          e.c   = mdl(opnd(a_sig, g), opnd(b_sig, g),
                      int'($signed(ae)), int'($signed(be)), int'($signed(ce)));
          q.push_back(e);
          mptr = (g + 1) % N;
        end
        if (q.size() > 0 && q[0].due == ncnt) begin
          exp_rv = 1'b1; exp_id = q[0].id; exp_c = q[0].c;
          void'(q.pop_front());
        end else begin
          exp_rv = 1'b0;
        end
      end
    end
  end

  // compare every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [N-1:0] er;
        int g;
        er = '0;
        g = mgrant(req_valid, mptr);
        if (cke && g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("resp_valid", resp_valid, exp_rv);
        chk("resp_id", resp_id, exp_id[1:0]);
        chk("c_significand", c_sig, exp_c);
        chk("busy", busy, q.size() != 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_sig[i*W +: W] = W'($urandom);
      b_sig[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic run_one(string nm, int id, int a, int b, logic [OW-1:0] expc);
    int seen = 0;
    step();
    req_valid = '0;
    req_valid[id] = 1'b1;
    a_sig[id*W +: W] = W'(a);
    b_sig[id*W +: W] = W'(b);
    step();
    req_valid = '0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      @(negedge clk); #1;
      if (resp_valid) seen = 1;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_c"}, c_sig, expc);
    chk({nm, "_id"}, resp_id, id[1:0]);
  endtask

  initial begin
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c", c_sig, 0);
    chk("rst_id", resp_id, 0);

    chk("mdl_t1", mdl(1536, 2048, -10, -10, -10), 18'd3072);
    chk("mdl_t2a", mdl(-1, 1, -10, -10, -10), 18'h3ffff);
    chk("mdl_t2b", mdl(-1536, 2048, -10, -10, -10), 18'h3f400);
    chk("mdl_left", mdl(3, 5, 2, 1, 0), 18'd120);

    step();
    rst = 1'b0; cke = 1'b1;
    run_one("t1", 0, 1536, 2048, 18'd3072);
    run_one("t2a", 1, -1, 1, 18'h3ffff);
    run_one("t2b", 3, -1536, 2048, 18'h3f400);

    // T3: all valid from reset
    step(); rst = 1'b1;
    step(); rst = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1 chk("t3_grant", req_ready, 4'b0001 << (i % 4));
      step();
    end
    req_valid = '0;
    repeat (L + 2) step();

    // T4: req2 alone, then req1 and req3 with ptr at 3
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      #1 chk("t4_solo", req_ready, 4'b0100);
      step();
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      #1 chk("t4_alt", req_ready, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      step();
    end
    req_valid = '0;
    repeat (L + 2) step();

    // T5: clock enable low mid-stream
    req_valid = 4'b1111;
    repeat (4) begin rand_ops(); step(); end
    cke = 1'b0;
    repeat (3) begin
      rand_ops();
      #1 chk("t5_frozen_ready", req_ready, 0);
      step();
    end
    cke = 1'b1;
    repeat (4) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (L + 3) step();

    // T6: asynchronous reset with products in flight
    req_valid = 4'b1111;
    repeat (3) begin rand_ops(); step(); end
    rst = 1'b1;
    #1;
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_c", c_sig, 0);
    chk("t6_id", resp_id, 0);
    #1 rst = 1'b0;
    #1 chk("t6_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    repeat (L + 3) step();

    // randomized phases; exponents change only while idle
    for (int ph = 0; ph < 6; ph++) begin
      ae = 16'($urandom_range(30) - 15);
      be = 16'($urandom_range(30) - 15);
      ce = 16'($urandom_range(30) - 15);
      for (int c = 0; c < 300; c++) begin
        req_valid = (ph % 2 == 0) ? N'($urandom) : N'($urandom | $urandom);
        cke = ($urandom_range(7) != 0);
        rand_ops();
        step();
      end
      req_valid = '0;
      cke = 1'b1;
      repeat (L + 3) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
